// File: rtl/multicycle_control.sv
// multicycle_control
//
// Main control unit for the multi-cycle RV32I core. It sequences each instruction
// over several states and shares one memory port that uses a req/ready handshake
// and has variable latency. It supports JAL/JALR/LUI/AUIPC, an optional memory
// timeout, and a sticky TRAP state that only reset clears.
//
// Parameters
//   MEM_TIMEOUT  : maximum consecutive wait cycles in a memory state (0 = wait forever)
//   ENABLE_JUMPS : JAL/JALR are legal when 1, trap when 0
//   ENABLE_UPPER : LUI/AUIPC are legal when 1, trap when 0
//
// Ports
//   i_Clk, i_Rst        clock (rising edge), asynchronous active-high reset
//   i_OPCode            IR[6:0]
//   i_MemReady          memory completes the current request this cycle
//   o_MemReq/o_MemWrite memory request / request is a store
//   o_IorD              address select (0 PC, 1 ALUOut)
//   o_IRWrite           IR load (OldPC <= PC)
//   o_PCWrite           unconditional PC load
//   o_PCWriteCond       PC load on branch condition
//   o_PCSource          00 ALU, 01 ALUOut, 10 ALU with bit0 cleared
//   o_ALUSrcA           00 PC, 01 rs1, 10 zero, 11 OldPC
//   o_ALUSrcB           00 rs2, 01 four, 10 immediate
//   o_ALUOp             00 add, 01 branch compare, 10 R funct, 11 I funct
//   o_RegWrite/o_WBSel  register write, source 00 ALUOut, 01 MDR, 10 OldPC+4
//   o_InstrDone         last cycle of an instruction
//   o_Error             high while in TRAP
//   o_State             current state code (debug)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, load IR and PC+4 on ready
// DECODE    | ALUOut <= OldPC + imm, dispatch on opcode
// MEM_ADDR  | ALUOut <= rs1 + imm
// MEM_READ  | load data from ALUOut into MDR
// MEM_WB    | rd <= MDR
// MEM_WRITE | store rs2 at ALUOut
// EXEC_R    | ALUOut <= rs1 op rs2
// EXEC_I    | ALUOut <= rs1 op imm
// ALU_WB    | rd <= ALUOut
// BRANCH    | compare rs1/rs2, PC <= branch target if taken
// JAL       | PC <= ALUOut, rd <= OldPC+4
// JALR      | PC <= (rs1+imm) & ~1, rd <= OldPC+4
// UPPER     | ALUOut <= 0+imm (LUI) or OldPC+imm (AUIPC)
// TRAP      | sticky error; only reset leaves it

module multicycle_control #(
    parameter int MEM_TIMEOUT  = 0,
    parameter bit ENABLE_JUMPS = 1'b1,
    parameter bit ENABLE_UPPER = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_OPCode,
    input  logic       i_MemReady,
    output logic       o_MemReq,
    output logic       o_MemWrite,
    output logic       o_IorD,
    output logic       o_IRWrite,
    output logic       o_PCWrite,
    output logic       o_PCWriteCond,
    output logic [1:0] o_PCSource,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic       o_RegWrite,
    output logic [1:0] o_WBSel,
    output logic       o_InstrDone,
    output logic       o_Error,
    output logic [3:0] o_State
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_UPPER     = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state_q, state_d;
    logic   timeout_hit;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] wait_cnt;
            logic          mem_wait;

            assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                               (state_q == S_MEM_WRITE)) && !i_MemReady;

            // The counter holds the number of wait cycles already spent in this
            // state. Ready on the cycle where it reaches the limit still wins,
            // because the FSM tests ready before timeout_hit.
            assign timeout_hit = mem_wait && (wait_cnt == CW'(MEM_TIMEOUT));

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst)
                    wait_cnt <= '0;
                else if (mem_wait && (state_d == state_q))
                    wait_cnt <= wait_cnt + CW'(1);
                else
                    wait_cnt <= '0;
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        o_MemReq      = 1'b0;
        o_MemWrite    = 1'b0;
        o_IorD        = 1'b0;
        o_IRWrite     = 1'b0;
        o_PCWrite     = 1'b0;
        o_PCWriteCond = 1'b0;
        o_PCSource    = 2'b00;
        o_ALUSrcA     = 2'b00;
        o_ALUSrcB     = 2'b00;
        o_ALUOp       = 2'b00;
        o_RegWrite    = 1'b0;
        o_WBSel       = 2'b00;
        o_InstrDone   = 1'b0;
        o_Error       = 1'b0;
        o_State       = state_q;

        case (state_q)
            S_FETCH: begin
                o_MemReq  = 1'b1;
                o_ALUSrcB = 2'b01;
                if (i_MemReady) begin
                    o_IRWrite = 1'b1;
                    o_PCWrite = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                o_ALUSrcA = 2'b11;
                o_ALUSrcB = 2'b10;
                case (i_OPCode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = ENABLE_JUMPS ? S_JAL : S_TRAP;
                    OP_JALR:           state_d = ENABLE_JUMPS ? S_JALR : S_TRAP;
                    OP_LUI, OP_AUIPC:  state_d = ENABLE_UPPER ? S_UPPER : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b10;
                state_d   = (i_OPCode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                o_MemReq = 1'b1;
                o_IorD   = 1'b1;
                if (i_MemReady)       state_d = S_MEM_WB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEM_WB: begin
                o_RegWrite  = 1'b1;
                o_WBSel     = 2'b01;
                o_InstrDone = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WRITE: begin
                o_MemReq   = 1'b1;
                o_MemWrite = 1'b1;
                o_IorD     = 1'b1;
                if (i_MemReady) begin
                    o_InstrDone = 1'b1;
                    state_d     = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC_R: begin
                o_ALUSrcA = 2'b01;
                o_ALUOp   = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b10;
                o_ALUOp   = 2'b11;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                o_RegWrite  = 1'b1;
                o_InstrDone = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                o_ALUSrcA     = 2'b01;
                o_ALUOp       = 2'b01;
                o_PCWriteCond = 1'b1;
                o_PCSource    = 2'b01;
                o_InstrDone   = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                o_PCWrite   = 1'b1;
                o_PCSource  = 2'b01;
                o_RegWrite  = 1'b1;
                o_WBSel     = 2'b10;
                o_InstrDone = 1'b1;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                o_ALUSrcA   = 2'b01;
                o_ALUSrcB   = 2'b10;
                o_PCWrite   = 1'b1;
                o_PCSource  = 2'b10;
                o_RegWrite  = 1'b1;
                o_WBSel     = 2'b10;
                o_InstrDone = 1'b1;
                state_d     = S_FETCH;
            end
            S_UPPER: begin
                // Opcode bit 5 separates LUI (zero base) from AUIPC (OldPC base).
                o_ALUSrcA = i_OPCode[5] ? 2'b10 : 2'b11;
                o_ALUSrcB = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_TRAP: begin
                o_Error = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Reset silences every output at once, including FETCH's request,
        // so no partial write escapes while reset is asserted.
        if (i_Rst) begin
            o_MemReq      = 1'b0;
            o_MemWrite    = 1'b0;
            o_IorD        = 1'b0;
            o_IRWrite     = 1'b0;
            o_PCWrite     = 1'b0;
            o_PCWriteCond = 1'b0;
            o_PCSource    = 2'b00;
            o_ALUSrcA     = 2'b00;
            o_ALUSrcB     = 2'b00;
            o_ALUOp       = 2'b00;
            o_RegWrite    = 1'b0;
            o_WBSel       = 2'b00;
            o_InstrDone   = 1'b0;
            o_Error       = 1'b0;
            o_State       = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Three instances share the inputs:
//   dut0: default parameters, dut1: MEM_TIMEOUT=8, dut2: jumps and upper disabled.
// The reference model follows each instruction's state path and applies the
// per-state output table.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opc;
    logic       rdy;
    logic [6:0] next_op;

    logic       mem_req[3], mem_write[3], iord[3], ir_write[3], pc_write[3], pc_write_cond[3];
    logic [1:0] pc_source[3], alu_src_a[3], alu_src_b[3], alu_op[3], wb_sel[3];
    logic       reg_write[3], instr_done[3], error[3];
    logic [3:0] state[3];
    logic [22:0] obs[3];

    int          ms[3];
    int          mw[3];
    logic [15:0] mp[3];
    logic [22:0] expv[3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control #(
            .MEM_TIMEOUT (g == 1 ? 8 : 0),
            .ENABLE_JUMPS(g == 2 ? 1'b0 : 1'b1),
            .ENABLE_UPPER(g == 2 ? 1'b0 : 1'b1)
        ) u_dut (
            .i_Clk        (clk),
            .i_Rst        (rst),
            .i_OPCode     (opc),
            .i_MemReady   (rdy),
            .o_MemReq     (mem_req[g]),
            .o_MemWrite   (mem_write[g]),
            .o_IorD       (iord[g]),
            .o_IRWrite    (ir_write[g]),
            .o_PCWrite    (pc_write[g]),
            .o_PCWriteCond(pc_write_cond[g]),
            .o_PCSource   (pc_source[g]),
            .o_ALUSrcA    (alu_src_a[g]),
            .o_ALUSrcB    (alu_src_b[g]),
            .o_ALUOp      (alu_op[g]),
            .o_RegWrite   (reg_write[g]),
            .o_WBSel      (wb_sel[g]),
            .o_InstrDone  (instr_done[g]),
            .o_Error      (error[g]),
            .o_State      (state[g])
        );
        assign obs[g] = {mem_req[g], mem_write[g], iord[g], ir_write[g], pc_write[g],
                         pc_write_cond[g], pc_source[g], alu_src_a[g], alu_src_b[g],
                         alu_op[g], reg_write[g], wb_sel[g], instr_done[g], error[g], state[g]};
    end

    function automatic int to_of(int k);
        return (k == 1) ? 8 : 0;
    endfunction

    // Remaining states after DECODE, low nibble first; an empty path means FETCH.
    function automatic logic [15:0] path_of(logic [6:0] op, int k);
        case (op)
            7'b0000011: return 16'h0432;
            7'b0100011: return 16'h0052;
            7'b0110011: return 16'h0086;
            7'b0010011: return 16'h0087;
            7'b1100011: return 16'h0009;
            7'b1101111: return (k == 2) ? 16'h000D : 16'h000A;
            7'b1100111: return (k == 2) ? 16'h000D : 16'h000B;
            7'b0110111, 7'b0010111: return (k == 2) ? 16'h000D : 16'h008C;
            default:    return 16'h000D;
        endcase
    endfunction

    function automatic logic [22:0] exp_of(int st, logic [6:0] op, logic r, logic rs);
        logic req, mwr, ad, irw, pcw, pcc, rw, dn, er;
        logic [1:0] pcs, a, b, alu, wb;
        {req, mwr, ad, irw, pcw, pcc, rw, dn, er} = '0;
        {pcs, a, b, alu, wb} = '0;
        case (st)
            0:  begin req = 1; b = 2'b01; irw = r; pcw = r; end
            1:  begin a = 2'b11; b = 2'b10; end
            2:  begin a = 2'b01; b = 2'b10; end
            3:  begin req = 1; ad = 1; end
            4:  begin rw = 1; wb = 2'b01; dn = 1; end
            5:  begin req = 1; mwr = 1; ad = 1; dn = r; end
            6:  begin a = 2'b01; alu = 2'b10; end
            7:  begin a = 2'b01; b = 2'b10; alu = 2'b11; end
            8:  begin rw = 1; dn = 1; end
            9:  begin a = 2'b01; alu = 2'b01; pcc = 1; pcs = 2'b01; dn = 1; end
            10: begin pcw = 1; pcs = 2'b01; rw = 1; wb = 2'b10; dn = 1; end
            11: begin a = 2'b01; b = 2'b10; pcw = 1; pcs = 2'b10; rw = 1; wb = 2'b10; dn = 1; end
            12: begin a = op[5] ? 2'b10 : 2'b11; b = 2'b10; end
            13: er = 1;
            default: ;
        endcase
        if (rs) return '0;
        return {req, mwr, ad, irw, pcw, pcc, pcs, a, b, alu, rw, wb, dn, er, 4'(st)};
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                ms[k] = 0; mw[k] = 0; mp[k] = '0;
            end else if (ms[k] == 13) begin
                ms[k] = 13;
            end else if (ms[k] == 0 || ms[k] == 3 || ms[k] == 5) begin
                if (rdy) begin
                    mw[k] = 0;
                    if (ms[k] == 0) ms[k] = 1;
                    else begin ms[k] = int'(mp[k][3:0]); mp[k] = mp[k] >> 4; end
                end else if (to_of(k) > 0 && mw[k] == to_of(k)) begin
                    ms[k] = 13; mw[k] = 0;
                end else begin
                    mw[k] = mw[k] + 1;
                end
            end else begin
                if (ms[k] == 1) mp[k] = path_of(opc, k);
                ms[k] = int'(mp[k][3:0]);
                mp[k] = mp[k] >> 4;
            end
        end
    end

    // One cycle: drive inputs after the falling edge, then form expectations.
    task automatic step(input logic r, input logic rs);
        @(negedge clk);
        rdy = r;
        rst = rs;
        if (ms[0] == 0) opc = next_op;
        #1;
        for (int k = 0; k < 3; k++) expv[k] = exp_of(ms[k], opc, rdy, rst);
        cyc++;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 23'd0) begin
                errors++;
                $display("FAIL reset_zero dut%0d got %h expected %h", k, obs[k], 23'd0);
            end
        end
        next_op = 7'b0110011;
        step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== expv[k]) begin
                errors++;
                $display("FAIL reset_release dut%0d cycle %0d got %h expected %h", k, cyc, obs[k], expv[k]);
            end
        end
        checks++;
        if (mem_req[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_req got %b expected 1", mem_req[0]);
        end
    endtask

    task automatic test_r_type();
        step(1'b0, 1'b1);
        next_op = 7'b0110011;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL r_type dut%0d cycle %0d got %h expected %h", k, i, obs[k], expv[k]);
                end
            end
            checks++;
            if (instr_done[0] !== (i == 4)) begin
                errors++;
                $display("FAIL r_type_done cycle %0d got %b expected %b", i, instr_done[0], (i == 4));
            end
        end
    endtask

    task automatic test_load_waits();
        int done_at;
        done_at = 0;
        step(1'b0, 1'b1);
        next_op = 7'b0000011;
        for (int i = 1; i <= 10; i++) begin
            step(!(i <= 3 || i == 7 || i == 8), 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL load_waits dut%0d cycle %0d got %h expected %h", k, i, obs[k], expv[k]);
                end
            end
            if (instr_done[0] === 1'b1 && done_at == 0) done_at = i;
        end
        checks++;
        if (done_at != 10) begin
            errors++;
            $display("FAIL load_latency got %0d expected 10", done_at);
        end
    endtask

    task automatic test_branch();
        step(1'b0, 1'b1);
        next_op = 7'b1100011;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL branch dut%0d cycle %0d got %h expected %h", k, i, obs[k], expv[k]);
                end
            end
        end
    endtask

    task automatic test_jal_upper();
        logic [6:0] ops[3];
        int         lens[3];
        ops  = '{7'b1101111, 7'b0010111, 7'b0110111};
        lens = '{3, 4, 4};
        step(1'b0, 1'b1);
        for (int n = 0; n < 3; n++) begin
            next_op = ops[n];
            for (int i = 1; i <= lens[n]; i++) begin
                step(1'b1, 1'b0);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== expv[k]) begin
                        errors++;
                        $display("FAIL jal_upper op%0d dut%0d cycle %0d got %h expected %h", n, k, i, obs[k], expv[k]);
                    end
                end
            end
        end
        checks++;
        if (state[2] !== 4'd13 || error[2] !== 1'b1) begin
            errors++;
            $display("FAIL jal_disabled_trap got state %0d err %b expected 13 1", state[2], error[2]);
        end
    endtask

    task automatic test_trap();
        step(1'b0, 1'b1);
        next_op = 7'b1111111;
        for (int i = 1; i <= 23; i++) begin
            step(1'b1, 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL illegal_trap dut%0d cycle %0d got %h expected %h", k, i, obs[k], expv[k]);
                end
            end
        end
        checks++;
        if (state[0] !== 4'd13) begin
            errors++;
            $display("FAIL trap_held got %0d expected 13", state[0]);
        end
        step(1'b0, 1'b1);
        next_op = 7'b0110011;
        step(1'b0, 1'b0);
        checks++;
        if (error[0] !== 1'b0 || state[0] !== 4'd0) begin
            errors++;
            $display("FAIL trap_exit got state %0d err %b expected 0 0", state[0], error[0]);
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b0, 1'b1);
            next_op = 7'b0110011;
            for (int i = 1; i <= 10; i++) begin
                step((pass == 1) && (i >= 9), 1'b0);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== expv[k]) begin
                        errors++;
                        $display("FAIL timeout p%0d dut%0d cycle %0d got %h expected %h", pass, k, i, obs[k], expv[k]);
                    end
                end
            end
            checks++;
            if (state[1] !== ((pass == 0) ? 4'd13 : 4'd1)) begin
                errors++;
                $display("FAIL timeout_limit p%0d got %0d expected %0d", pass, state[1], (pass == 0) ? 13 : 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1);
        next_op = 7'b0100011;
        for (int i = 1; i <= 4; i++) begin
            step(i != 4, 1'b0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL store_wait dut%0d cycle %0d got %h expected %h", k, i, obs[k], expv[k]);
                end
            end
        end
        checks++;
        if (mem_write[0] !== 1'b1) begin
            errors++;
            $display("FAIL store_active got %b expected 1", mem_write[0]);
        end
        step(1'b0, 1'b1);
        checks++;
        if (mem_write[0] !== 1'b0 || mem_req[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_store got wr %b req %b expected 0 0", mem_write[0], mem_req[0]);
        end
    endtask

    task automatic test_random();
        logic [6:0] legal[9];
        int         sel;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        step(1'b0, 1'b1);
        for (int i = 1; i <= 600; i++) begin
            sel = int'($urandom_range(0, 9));
            next_op = (sel < 9) ? legal[sel] : 7'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== expv[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cycle %0d op %b got %h expected %h", k, i, opc, obs[k], expv[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        opc = 7'd0;
        next_op = 7'd0;
        for (int k = 0; k < 3; k++) begin ms[k] = 0; mw[k] = 0; mp[k] = '0; end
        test_reset();
        test_r_type();
        test_load_waits();
        test_branch();
        test_jal_upper();
        test_trap();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
